// File: rtl/uart_tx_queue_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_queue_pkg
// Shared definitions for the buffered UART transmit front-end: the default
// word width and the encoding of the transmit handshake state machine.
// ---------------------------------------------------------------------------
package uart_tx_queue_pkg;

    localparam int DEF_DATA_W = 8;

    // Transmit handshake states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,   // waiting for queued data and an idle transmitter
        ST_START     = 2'd1,   // tx_start pulse is on the wire this cycle
        ST_WAIT_BUSY = 2'd2,   // waiting (bounded) for the transmitter to take the word
        ST_WAIT_DONE = 2'd3    // transmitter is shifting; wait for it to finish
    } tx_state_e;

endpackage

// File: rtl/uart_tx_queue_mem.sv
// ---------------------------------------------------------------------------
// uart_tx_queue_mem
// Storage array for the transmit queue: DEPTH x DATA_W registers with one
// synchronous write port and one asynchronous read port.
// Ports:
//   clk    in   clock
//   we     in   write enable (word stored on the rising edge)
//   waddr  in   write address
//   wdata  in   word to store
//   raddr  in   read address
//   rdata  out  word at raddr (combinational)
// ---------------------------------------------------------------------------
module uart_tx_queue_mem
    import uart_tx_queue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(1 << ADDR_W)-1];

    // Write port; contents are only ever read after being written, so no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
// Buffered front-end for the UART transmitter. Words from a producer are
// absorbed into a circular FIFO; one word at a time is handed to the
// transmitter with a tx_start pulse, then the block waits for tx_busy to rise
// and fall (or for a bounded timeout) before handing over the next word.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   wr_valid     in   producer offers wr_data
//   wr_data      in   word to enqueue
//   wr_ready     out  queue not full
//   full         out  level == DEPTH
//   almost_full  out  level >= AF_LEVEL
//   level        out  words stored (0..DEPTH)
//   overflow     out  sticky: write attempted while full
//   flush        in   discard queued words and clear overflow
//   tx_busy      in   transmitter is shifting a word
//   tx_start     out  one-cycle pulse, tx_data valid
//   tx_data      out  registered word for the transmitter
// ---------------------------------------------------------------------------
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = 4,
    parameter int AF_LEVEL  = 12,
    parameter int BUSY_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              flush,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data
);

    localparam int                LVL_W    = ADDR_W + 1;
    localparam logic [LVL_W-1:0]  LVL_ZERO = LVL_W'(0);
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0]  AF_L     = LVL_W'(AF_LEVEL);
    localparam int                TMR_W    = $clog2(BUSY_WAIT) + 1;
    localparam logic [TMR_W-1:0]  TMR_ZERO = TMR_W'(0);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(BUSY_WAIT - 1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [LVL_W-1:0]  wr_ptr_r, rd_ptr_r, level_r;
    logic [LVL_W-1:0]  wr_ptr_nxt_s, rd_ptr_nxt_s, level_nxt_s;
    logic              full_r, af_r, wr_ready_r, overflow_r;
    logic              full_nxt_s, wr_acc_s, pop_s;
    logic              tx_start_r;
    logic [DATA_W-1:0] tx_data_r, rd_data_s;
    logic [TMR_W-1:0]  timer_r, timer_nxt_s;
    tx_state_e         state_r, state_nxt_s;

    uart_tx_queue_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_r[ADDR_W-1:0]),
        .rdata (rd_data_s)
    );

    // Queue bookkeeping: accepted write, pointer advance and next level.
    // A write is refused on a full cycle even if a pop frees a slot, and
    // flush discards both the stored words and any write on the same cycle.
    always_comb begin
        wr_acc_s     = wr_valid & ~full_r & ~flush;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        level_nxt_s  = level_r;
        if (flush) begin
            rd_ptr_nxt_s = wr_ptr_r;
            level_nxt_s  = LVL_ZERO;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_nxt_s = wr_ptr_r + LVL_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + LVL_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({wr_acc_s, pop_s})
                2'b10:   level_nxt_s = level_r + LVL_ONE;
                2'b01:   level_nxt_s = level_r - LVL_ONE;
                default: level_nxt_s = level_r;
            endcase
        end
        full_nxt_s = (wr_ptr_nxt_s[ADDR_W] != rd_ptr_nxt_s[ADDR_W]) &&
                     (wr_ptr_nxt_s[ADDR_W-1:0] == rd_ptr_nxt_s[ADDR_W-1:0]);
    end

    // Pointers, level and producer-facing flags, all registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= LVL_ZERO;
            rd_ptr_r   <= LVL_ZERO;
            level_r    <= LVL_ZERO;
            full_r     <= 1'b0;
            af_r       <= 1'b0;
            wr_ready_r <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            level_r    <= level_nxt_s;
            full_r     <= full_nxt_s;
            af_r       <= (level_nxt_s >= AF_L);
            wr_ready_r <= ~full_nxt_s;
            if (flush) begin
                overflow_r <= 1'b0;
            end else if (wr_valid & full_r) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Handshake next-state: pop only from IDLE with data, an idle transmitter
    // and no flush, so a stale tx_busy can never trigger a second send
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((level_r != LVL_ZERO) && !tx_busy && !flush) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                timer_nxt_s = TMR_ZERO;
                state_nxt_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    timer_nxt_s = timer_r + TMR_ONE;
                    // Transmitter never acknowledged: treat the word as sent
                    if (timer_r == TMR_LAST) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WAIT_BUSY;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake state, timeout timer and registered transmitter outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            timer_r    <= TMR_ZERO;
            tx_start_r <= 1'b0;
            tx_data_r  <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            timer_r    <= timer_nxt_s;
            tx_start_r <= pop_s;
            if (pop_s) begin
                tx_data_r <= rd_data_s;
            end else begin
                tx_data_r <= tx_data_r;
            end
        end
    end

    assign wr_ready    = wr_ready_r;
    assign full        = full_r;
    assign almost_full = af_r;
    assign level       = level_r;
    assign overflow    = overflow_r;
    assign tx_start    = tx_start_r;
    assign tx_data     = tx_data_r;

endmodule
